// File: rtl/snake_pkg.sv
// Shared codes for the snake game: FSM states, collision results and
// movement directions, used by the controller and the drawing stage.
package snake_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_OVER = 2'b11
    } game_state_t;

    typedef enum logic [1:0] {
        COL_NONE  = 2'b00,
        COL_FATAL = 2'b01,
        COL_APPLE = 2'b10
    } collision_t;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_RIGHT = 2'b01,
        DIR_DOWN  = 2'b10,
        DIR_LEFT  = 2'b11
    } dir_t;

    localparam int SCORE_W = 8;

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchronizer for the asynchronous start button plus a
// rising-edge detector producing a one-cycle start pulse.
module btn_sync (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic start_edge
);

    logic s0, s1, s2;

    always_ff @(posedge clk) begin
        if (reset) begin
            s0 <= 1'b0;
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s0 <= btn;
            s1 <= s0;
            s2 <= s1;
        end
    end

    assign start_edge = s1 & ~s2;

endmodule

// File: rtl/snake_game_ctrl.sv
// Game controller: per-frame collision detection, scoring, step timing
// and the IDLE/PLAY/GAME_OVER state machine.
module snake_game_ctrl
    import snake_pkg::*;
#(
    parameter int H_RES           = 640,
    parameter int V_RES           = 480,
    parameter int BORDER          = 10,
    parameter int FRAMES_PER_STEP = 8,
    parameter int GO_FRAMES       = 60
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [9:0]   x_pos,
    input  logic [9:0]   y_pos,
    input  logic         frame_end,
    input  logic         head_active,
    input  logic         body_active,
    input  logic         apple_active,
    input  logic         btn_start,
    output logic         update,
    output logic [1:0]   collision,
    output logic [1:0]   game_state,
    output logic [SCORE_W-1:0] score
);

    localparam int SW = $clog2(FRAMES_PER_STEP);
    localparam int GW = $clog2(GO_FRAMES + 1);

    game_state_t state_q, state_d;
    logic        start_edge;
    logic        enter_play;
    logic [9:0]  x_d, y_d;
    logic        wall_px;
    logic        fatal_f, apple_f;
    logic [SW-1:0] step_cnt;
    logic [GW-1:0] go_cnt;
    logic        step_wrap;
    logic        go_done;
    collision_t  coll_q;

    btn_sync u_btn_sync (
        .clk        (clk),
        .reset      (reset),
        .btn        (btn_start),
        .start_edge (start_edge)
    );

    // The *_active inputs lag the pixel coordinates by one cycle.
    assign wall_px = (x_d < 10'(BORDER)) || (x_d >= 10'(H_RES - BORDER)) ||
                     (y_d < 10'(BORDER)) || (y_d >= 10'(V_RES - BORDER));

    assign step_wrap = (step_cnt == SW'(FRAMES_PER_STEP - 1));
    assign go_done   = (go_cnt >= GW'(GO_FRAMES));

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        enter_play = 1'b0;
        case (state_q)
            ST_IDLE: if (start_edge) begin
                state_d    = ST_PLAY;
                enter_play = 1'b1;
            end
            ST_PLAY: if (frame_end && fatal_f) state_d = ST_OVER;
            ST_OVER: if (start_edge && go_done) begin
                state_d    = ST_PLAY;
                enter_play = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_d      <= '0;
            y_d      <= '0;
            fatal_f  <= 1'b0;
            apple_f  <= 1'b0;
            coll_q   <= COL_NONE;
            score    <= '0;
            step_cnt <= '0;
            go_cnt   <= '0;
            update   <= 1'b0;
        end else begin
            x_d    <= x_pos;
            y_d    <= y_pos;
            update <= 1'b0;

            if (frame_end) begin
                fatal_f <= 1'b0;
                apple_f <= 1'b0;
            end else if (state_q == ST_PLAY) begin
                if (head_active && (body_active || wall_px)) fatal_f <= 1'b1;
                if (head_active && apple_active)             apple_f <= 1'b1;
            end

            if (enter_play) begin
                score  <= '0;
                coll_q <= COL_NONE;
                if (state_q == ST_IDLE) step_cnt <= '0;
            end else if (frame_end) begin
                if (state_q == ST_PLAY) begin
                    coll_q   <= fatal_f ? COL_FATAL : (apple_f ? COL_APPLE : COL_NONE);
                    step_cnt <= step_wrap ? '0 : step_cnt + 1'b1;
                    if (!fatal_f && apple_f && score != '1) score <= score + 1'b1;
                    // No step on the frame that ends the game.
                    if (step_wrap && !fatal_f) update <= 1'b1;
                end else begin
                    // The fatal code stays visible for the first GAME_OVER frame.
                    coll_q <= COL_NONE;
                end
            end

            if (state_q != ST_OVER)
                go_cnt <= '0;
            else if (frame_end && !go_done)
                go_cnt <= go_cnt + 1'b1;
        end
    end

    assign collision  = coll_q;
    assign game_state = state_q;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Directed plus randomized bench for snake_game_ctrl against a frame-level
// behavioural model of the game rules.
module tb_snake_game_ctrl;

    localparam int FPS = 8;
    localparam int GOF = 60;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] x_pos = '0, y_pos = '0;
    logic       frame_end = 1'b0;
    logic       head_active = 1'b0, body_active = 1'b0, apple_active = 1'b0;
    logic       btn_start = 1'b0;
    logic       update;
    logic [1:0] collision, game_state;
    logic [7:0] score;

    int checks = 0;
    int failures = 0;

    // model: state codes are the output encodings 0 idle, 1 play, 3 over
    int m_state, m_score, m_coll, m_step, m_go;
    bit m_fatal, m_apple, exp_upd;

    snake_game_ctrl #(.H_RES(640), .V_RES(480), .BORDER(10),
                      .FRAMES_PER_STEP(FPS), .GO_FRAMES(GOF)) dut (
        .clk(clk), .reset(reset), .x_pos(x_pos), .y_pos(y_pos),
        .frame_end(frame_end), .head_active(head_active),
        .body_active(body_active), .apple_active(apple_active),
        .btn_start(btn_start), .update(update), .collision(collision),
        .game_state(game_state), .score(score)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit is_wall(int x, int y);
        return x < 10 || x >= 630 || y < 10 || y >= 470;
    endfunction

    task automatic model_reset();
        m_state = 0; m_score = 0; m_coll = 0; m_step = 0; m_go = 0;
        m_fatal = 0; m_apple = 0;
    endtask

    task automatic chk_outputs(input string tag, input bit upd);
        chk({tag, "_state"}, game_state, m_state);
        chk({tag, "_coll"}, collision, m_coll);
        chk({tag, "_score"}, score, m_score);
        chk({tag, "_update"}, update, upd);
    endtask

    task automatic pix(input int x, input int y, input bit h, input bit b, input bit a);
        @(negedge clk);
        x_pos = 10'(x); y_pos = 10'(y);
        @(negedge clk);
        head_active = h; body_active = b; apple_active = a;
        @(negedge clk);
        head_active = 0; body_active = 0; apple_active = 0;
        if (m_state == 1 && h) begin
            if (b || is_wall(x, y)) m_fatal = 1;
            if (a) m_apple = 1;
        end
    endtask

    task automatic frame(input string tag);
        @(negedge clk); frame_end = 1;
        @(negedge clk); frame_end = 0;
        exp_upd = 0;
        if (m_state == 1) begin
            m_coll = m_fatal ? 1 : (m_apple ? 2 : 0);
            if (!m_fatal && m_apple && m_score < 255) m_score++;
            m_step = (m_step + 1) % FPS;
            if (m_fatal) begin m_state = 3; m_go = 0; end
            else if (m_step == 0) exp_upd = 1;
        end else begin
            m_coll = 0;
            if (m_state == 3 && m_go < GOF) m_go++;
        end
        m_fatal = 0; m_apple = 0;
        chk_outputs(tag, exp_upd);
        @(negedge clk);
        chk({tag, "_upd_clr"}, update, 0);
    endtask

    task automatic press(input string tag);
        @(negedge clk); btn_start = 1;
        repeat (4) @(negedge clk);
        btn_start = 0;
        repeat (3) @(negedge clk);
        if (m_state == 0) begin
            m_state = 1; m_score = 0; m_coll = 0; m_step = 0;
        end else if (m_state == 3 && m_go >= GOF) begin
            m_state = 1; m_score = 0; m_coll = 0;
        end
        chk_outputs(tag, 0);
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        reset = 0;
        @(negedge clk);
        chk_outputs("reset", 0);

        press("start");
        for (int i = 0; i < 2 * FPS; i++) frame("step");

        pix(100, 100, 1, 0, 1);
        frame("apple");
        frame("apple_after");

        while (m_step != FPS - 1) frame("align");
        pix(5, 100, 1, 0, 0);
        frame("wall");

        for (int i = 0; i < 30; i++) frame("go_wait");
        press("go_early");
        for (int i = 0; i < 30; i++) frame("go_wait2");
        press("go_restart");

        pix(300, 200, 1, 0, 1);
        frame("apple2");
        pix(200, 200, 1, 1, 1);
        frame("simul");

        for (int i = 0; i < GOF; i++) frame("go_wait3");
        press("restart2");

        repeat (200) begin
            int n;
            n = $urandom_range(0, 3);
            for (int k = 0; k < n; k++)
                pix($urandom_range(0, 639), $urandom_range(0, 479),
                    1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 3) == 0));
            frame("rand");
            if ($urandom_range(0, 15) == 0 || m_state == 0 ||
                (m_state == 3 && m_go >= GOF)) press("rand_press");
        end

        if (m_state == 3) begin
            while (m_go < GOF) frame("sat_prep");
            press("sat_start");
        end
        for (int i = 0; i < 260; i++) begin
            pix(100, 100, 1, 0, 1);
            frame("sat");
        end

        while (m_step != FPS - 1) frame("align2");
        @(negedge clk); frame_end = 1; reset = 1;
        @(negedge clk); frame_end = 0; reset = 0;
        model_reset();
        chk_outputs("mid_reset", 0);
        @(negedge clk);
        chk_outputs("post_reset", 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
